bep_frame_controller: RTL and testbench

BEP_FRAME_CONTROLLER -- requirements
Module: bep_frame_controller

---
 rtl/bep_frame_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_bep_frame_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bep_frame_controller.sv
// Frame controller for a Manchester bit-stream: hunts for a sync word, decodes the
// address/length header and delivers payload bytes through a valid/ready handshake.
module bep_frame_controller #(
  parameter logic [7:0]  SYNC_WORD      = 8'hD5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       bit_strobe,
  input  logic       bit_data,
  input  logic [3:0] address,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [3:0] byte_index,
  output logic       frame_active,
  output logic       frame_done,
  output logic       frame_error,
  output logic [1:0] error_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_SKIP    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic [3:0]      r_byte_cnt;
  logic [3:0]      r_len;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_byte_data;
  logic            r_byte_valid;
  logic [3:0]      r_byte_index;
  logic            r_frame_active;
  logic            r_frame_done;
  logic            r_frame_error;
  logic [1:0]      r_error_code;

  logic            w_stb;
  logic [7:0]      w_shift_nxt;
  logic            w_byte_end;
  logic            w_sync_hit;
  logic            w_hdr_match;
  logic            w_hdr_empty;
  logic            w_last_byte;
  logic            w_overrun;
  logic            w_accept;
  logic [TW-1:0]   w_timer_inc;
  logic            w_timeout;
  logic            w_load;
  logic            w_done;
  logic            w_err;
  logic [1:0]      w_code_nxt;

  assign w_stb       = enable & bit_strobe;
  assign w_shift_nxt = {r_shift[6:0], bit_data};
  assign w_byte_end  = w_stb & (r_bit_cnt == 3'd7);
  assign w_sync_hit  = (r_state == ST_HUNT) & w_stb & (w_shift_nxt == SYNC_WORD);
  assign w_hdr_match = (w_shift_nxt[7:4] == address);
  assign w_hdr_empty = (w_shift_nxt[3:0] == 4'd0);
  assign w_last_byte = (r_byte_cnt == (r_len - 4'd1));
  assign w_overrun   = r_byte_valid & ~byte_ready;
  assign w_accept    = enable & r_byte_valid & byte_ready;
  assign w_timer_inc = r_timer + TW'(1);
  // Idle cycles only count inside a frame; a strobe in the same cycle always wins.
  assign w_timeout   = enable & ~bit_strobe & (r_state != ST_HUNT) & (w_timer_inc == TMAX);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT: begin
        if (w_sync_hit) w_state_nxt = ST_HEADER;
        else            w_state_nxt = ST_HUNT;
      end
      ST_HEADER: begin
        if (w_timeout)                     w_state_nxt = ST_HUNT;
        else if (w_byte_end && w_hdr_empty) w_state_nxt = ST_HUNT;
        else if (w_byte_end && w_hdr_match) w_state_nxt = ST_PAYLOAD;
        else if (w_byte_end)                w_state_nxt = ST_SKIP;
        else                                w_state_nxt = ST_HEADER;
      end
      ST_PAYLOAD: begin
        if (w_timeout)                                  w_state_nxt = ST_HUNT;
        else if (w_byte_end && (w_overrun || w_last_byte)) w_state_nxt = ST_HUNT;
        else                                            w_state_nxt = ST_PAYLOAD;
      end
      ST_SKIP: begin
        if (w_timeout)                      w_state_nxt = ST_HUNT;
        else if (w_byte_end && w_last_byte) w_state_nxt = ST_HUNT;
        else                                w_state_nxt = ST_SKIP;
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // Output/event decode
  always_comb begin
    w_load     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_code_nxt = r_error_code;
    case (r_state)
      ST_HUNT: begin
        if (w_sync_hit) w_code_nxt = 2'b00;
        else            w_code_nxt = r_error_code;
      end
      ST_HEADER: begin
        if (w_timeout) begin
          w_err      = 1'b1;
          w_code_nxt = 2'b01;
        end else if (w_byte_end && w_hdr_empty) begin
          w_done = w_hdr_match;
        end else begin
          w_done = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (w_timeout) begin
          w_err      = 1'b1;
          w_code_nxt = 2'b01;
        end else if (w_byte_end && w_overrun) begin
          w_err      = 1'b1;
          w_code_nxt = 2'b10;
        end else if (w_byte_end) begin
          w_load = 1'b1;
          w_done = w_last_byte;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_SKIP: begin
        if (w_timeout) begin
          w_err      = 1'b1;
          w_code_nxt = 2'b01;
        end else begin
          w_err = 1'b0;
        end
      end
      default: w_err = 1'b0;
    endcase
  end

  // Datapath, counters and registered outputs; enable low freezes everything but pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift        <= 8'h00;
      r_bit_cnt      <= 3'd0;
      r_byte_cnt     <= 4'd0;
      r_len          <= 4'd0;
      r_timer        <= '0;
      r_byte_data    <= 8'h00;
      r_byte_valid   <= 1'b0;
      r_byte_index   <= 4'd0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_error  <= 1'b0;
      r_error_code   <= 2'b00;
    end else begin
      r_frame_done   <= w_done;
      r_frame_error  <= w_err;
      r_error_code   <= w_code_nxt;
      r_frame_active <= (w_state_nxt != ST_HUNT);
      if (enable) begin
        if (w_stb) r_shift <= w_shift_nxt;
        else       r_shift <= r_shift;

        if (w_sync_hit)                         r_bit_cnt <= 3'd0;
        else if (w_stb && r_state != ST_HUNT)   r_bit_cnt <= r_bit_cnt + 3'd1;
        else                                    r_bit_cnt <= r_bit_cnt;

        if (w_stb || w_timeout || r_state == ST_HUNT) r_timer <= '0;
        else                                          r_timer <= w_timer_inc;

        if (w_sync_hit) begin
          r_byte_cnt <= 4'd0;
        end else if (w_byte_end && r_state == ST_HEADER) begin
          r_byte_cnt <= 4'd0;
          r_len      <= w_shift_nxt[3:0];
        end else if (w_byte_end && (r_state == ST_PAYLOAD || r_state == ST_SKIP)) begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
        end else begin
          r_byte_cnt <= r_byte_cnt;
        end

        // A load in the same cycle as an accept replaces the old byte seamlessly.
        if (w_load) begin
          r_byte_data  <= w_shift_nxt;
          r_byte_index <= r_byte_cnt;
          r_byte_valid <= 1'b1;
        end else if (w_accept) begin
          r_byte_valid <= 1'b0;
        end else begin
          r_byte_valid <= r_byte_valid;
        end
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  assign byte_data    = r_byte_data;
  assign byte_valid   = r_byte_valid;
  assign byte_index   = r_byte_index;
  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;
  assign frame_error  = r_frame_error;
  assign error_code   = r_error_code;

endmodule

// File: tb/tb_bep_frame_controller.sv
// Directed bench for bep_frame_controller: a frame table plus hand-written sequences
// for timeout, enable freeze, same-cycle accept and mid-frame reset.
module tb_bep_frame_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       bit_strobe;
  logic       bit_data;
  logic [3:0] address;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [3:0] byte_index;
  logic       frame_active;
  logic       frame_done;
  logic       frame_error;
  logic [1:0] error_code;

  int n_checks = 0;
  int n_pass   = 0;

  int   n_done = 0;
  int   n_err  = 0;
  int   n_rise = 0;
  logic prev_valid = 1'b0;

  bep_frame_controller dut (
    .clock(clock), .reset(reset), .enable(enable), .bit_strobe(bit_strobe),
    .bit_data(bit_data), .address(address), .byte_ready(byte_ready),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_index(byte_index),
    .frame_active(frame_active), .frame_done(frame_done),
    .frame_error(frame_error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  // Pulse and byte-arrival counters sampled mid-cycle
  always @(negedge clock) begin
    n_done     <= n_done + (frame_done ? 1 : 0);
    n_err      <= n_err + (frame_error ? 1 : 0);
    n_rise     <= n_rise + ((byte_valid && !prev_valid) ? 1 : 0);
    prev_valid <= byte_valid;
  end

  typedef struct {
    logic [7:0] hdr;
    int         nb;
    logic [7:0] p0;
    logic [7:0] p1;
    logic       rdy;
    int         e_bytes;
    int         e_done;
    int         e_err;
    logic [1:0] e_code;
    logic       e_chk_data;
    logic [7:0] e_data;
    logic [3:0] e_idx;
    logic       e_valid_end;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_strobe = 1'b1;
    bit_data   = b;
    tick();
    bit_strobe = 1'b0;
    bit_data   = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic drain();
    byte_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s_done, s_err, s_rise;
    s_done = n_done; s_err = n_err; s_rise = n_rise;
    byte_ready = v.rdy;
    send_bits(8'hD5, 8);
    send_bits(v.hdr, 8);
    if (v.nb > 0) send_bits(v.p0, 8);
    if (v.nb > 1) send_bits(v.p1, 8);
    tick();
    check({tag, " bytes"}, n_rise - s_rise, v.e_bytes);
    check({tag, " done"}, n_done - s_done, v.e_done);
    check({tag, " err"}, n_err - s_err, v.e_err);
    check({tag, " code"}, error_code, v.e_code);
    check({tag, " active"}, frame_active, 1'b0);
    check({tag, " valid_end"}, byte_valid, v.e_valid_end);
    if (v.e_chk_data) begin
      check({tag, " data"}, byte_data, v.e_data);
      check({tag, " idx"}, byte_index, v.e_idx);
    end
    drain();
  endtask

  initial begin
    int   s_err;
    logic err_seen;

    //         hdr    nb p0     p1     rdy   bytes done err code   chk   data   idx   vend
    vecs[0] = '{8'h32, 2, 8'hAA, 8'h55, 1'b1, 2, 1, 0, 2'b00, 1'b1, 8'h55, 4'd1, 1'b0};
    vecs[1] = '{8'h52, 2, 8'hAA, 8'h55, 1'b1, 0, 0, 0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[2] = '{8'h30, 0, 8'h00, 8'h00, 1'b1, 0, 1, 0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[3] = '{8'h31, 1, 8'h3C, 8'h00, 1'b1, 1, 1, 0, 2'b00, 1'b1, 8'h3C, 4'd0, 1'b0};
    vecs[4] = '{8'h50, 0, 8'h00, 8'h00, 1'b1, 0, 0, 0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[5] = '{8'h32, 2, 8'h11, 8'h22, 1'b0, 1, 0, 1, 2'b10, 1'b1, 8'h11, 4'd0, 1'b1};

    reset = 1'b1; enable = 1'b1; bit_strobe = 1'b0; bit_data = 1'b0;
    address = 4'd3; byte_ready = 1'b1;
    tick(); tick();
    check("rst valid", byte_valid, 1'b0);
    check("rst data", byte_data, 8'h00);
    check("rst active", frame_active, 1'b0);
    check("rst code", error_code, 2'b00);
    check("rst pulses", {frame_done, frame_error}, 2'b00);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero-length header: done one cycle after the 8th header strobe
    send_bits(8'hD5, 8);
    send_bits(8'h30, 8);
    check("l0 done", frame_done, 1'b1);
    check("l0 valid", byte_valid, 1'b0);
    check("l0 active", frame_active, 1'b0);
    tick();
    check("l0 done pulse", frame_done, 1'b0);

    // New byte completes while old one is accepted in the same cycle
    byte_ready = 1'b0;
    send_bits(8'hD5, 8);
    send_bits(8'h32, 8);
    send_bits(8'hAA, 8);
    check("acc first", {byte_valid, byte_data}, {1'b1, 8'hAA});
    send_bits(8'h55, 7);
    byte_ready = 1'b1;
    send_bit(1'b1);
    check("acc data", {byte_valid, byte_data, byte_index}, {1'b1, 8'h55, 4'd1});
    check("acc done", {frame_done, frame_error, error_code}, {1'b1, 1'b0, 2'b00});
    tick();
    check("acc drained", byte_valid, 1'b0);

    // Timeout: error exactly TIMEOUT_CYCLES edges after the last strobe
    send_bits(8'hD5, 8);
    send_bits(8'h31, 8);
    err_seen = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      err_seen = err_seen | frame_error;
    end
    check("to early", err_seen, 1'b0);
    check("to active before", frame_active, 1'b1);
    tick();
    check("to err", {frame_error, error_code, frame_active}, {1'b1, 2'b01, 1'b0});
    tick();
    check("to pulse", frame_error, 1'b0);

    // Enable low for 1000 cycles mid-payload, with ignored strobes
    s_err = n_err;
    send_bits(8'hD5, 8);
    send_bits(8'h32, 8);
    send_bits(8'hAA, 8);
    send_bits(8'h55, 4);
    enable = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      bit_strobe = (k % 97 == 5);
      bit_data   = 1'b1;
      tick();
    end
    bit_strobe = 1'b0;
    enable = 1'b1;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1);
    check("en done", {frame_done, byte_valid, byte_data, byte_index}, {1'b1, 1'b1, 8'h55, 4'd1});
    tick();
    check("en no error", n_err - s_err, 0);
    check("en code", error_code, 2'b00);
    drain();

    // Reset mid-frame discards the frame silently, then hunting resumes
    s_err = n_err;
    send_bits(8'hD5, 8);
    send_bits(8'h32, 8);
    send_bits(8'hAA, 4);
    reset = 1'b1;
    tick();
    check("mrst state", {frame_active, byte_valid, error_code}, {1'b0, 1'b0, 2'b00});
    reset = 1'b0;
    tick();
    tick();
    check("mrst no err", n_err - s_err, 0);
    run_vec(vecs[0], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
